// File: rtl/rsp_xarbiter_lock.sv
// Response-path crossbar arbiter with packet locking: one round-robin arbiter per target.
// A target stays with one initiator from its first accepted beat until the last beat or an idle timeout.
module rsp_xarbiter_lock #(
  parameter int unsigned NI      = 5,
  parameter int unsigned NT      = 3,
  parameter int unsigned LOCK_TO = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NI*NT-1:0] I_req,
  input  logic [NI-1:0]    I_last,
  input  logic [NT-1:0]    T_rdy,
  output logic [NI*NT-1:0] I_vreq,
  output logic [NT-1:0]    T_lock
);

  localparam int unsigned TOW = (LOCK_TO == 0) ? 1 : $clog2(LOCK_TO + 1);
  localparam int unsigned OW  = $clog2(NI);
  localparam int unsigned IW  = $clog2(NI * NT);

  function automatic logic [IW-1:0] bit_of(input int i, input int t);
    return IW'(i * int'(NT) + t);
  endfunction

  // Round-robin index arithmetic; both operands are below NI.
  function automatic int wrap_add(input int a, input int b);
    int s;
    s = a + b;
    return (s >= int'(NI)) ? s - int'(NI) : s;
  endfunction

  logic [NT-1:0]    lock_q, lock_d;
  logic [OW-1:0]    owner_q [NT];
  logic [OW-1:0]    owner_d [NT];
  logic [OW-1:0]    ptr_q   [NT];
  logic [OW-1:0]    ptr_d   [NT];
  logic [TOW-1:0]   tcnt_q  [NT];
  logic [TOW-1:0]   tcnt_d  [NT];

  logic [NI*NT-1:0] avail;
  logic [NI*NT-1:0] gnt;
  logic [NT-1:0]    gnt_any;
  logic [OW-1:0]    win [NT];

  always_comb begin
    avail = '0;
    for (int i = 0; i < int'(NI); i++) begin
      for (int t = 0; t < int'(NT); t++) begin
        avail[bit_of(i, t)] = I_req[bit_of(i, t)] & T_rdy[t];
      end
    end
  end

  always_comb begin
    gnt     = '0;
    gnt_any = '0;
    for (int t = 0; t < int'(NT); t++) begin
      win[t] = '0;
      if (lock_q[t]) begin
        if (avail[bit_of(int'(owner_q[t]), t)]) begin
          gnt_any[t] = 1'b1;
          win[t]     = owner_q[t];
        end
      end else begin
        // Scan downwards so the closest requester above ptr is the last one to overwrite win.
        for (int k = int'(NI) - 1; k >= 0; k--) begin
          if (avail[bit_of(wrap_add(int'(ptr_q[t]), k), t)]) begin
            gnt_any[t] = 1'b1;
            win[t]     = OW'(wrap_add(int'(ptr_q[t]), k));
          end
        end
      end
      if (gnt_any[t]) begin
        gnt[bit_of(int'(win[t]), t)] = 1'b1;
      end
    end
  end

  assign I_vreq = rst ? '0 : gnt;
  assign T_lock = lock_q;

  always_comb begin
    lock_d = lock_q;
    for (int t = 0; t < int'(NT); t++) begin
      owner_d[t] = owner_q[t];
      ptr_d[t]   = ptr_q[t];
      tcnt_d[t]  = tcnt_q[t];
      if (gnt_any[t]) begin
        tcnt_d[t] = '0;
        if (I_last[win[t]]) begin
          lock_d[t] = 1'b0;
          ptr_d[t]  = OW'(wrap_add(int'(win[t]), 1));
        end else begin
          lock_d[t]  = 1'b1;
          owner_d[t] = win[t];
        end
      end else if (lock_q[t] && (LOCK_TO != 0)) begin
        if (tcnt_q[t] == TOW'(LOCK_TO - 1)) begin
          lock_d[t] = 1'b0;
          ptr_d[t]  = OW'(wrap_add(int'(owner_q[t]), 1));
          tcnt_d[t] = '0;
        end else begin
          tcnt_d[t] = tcnt_q[t] + TOW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= '0;
      for (int t = 0; t < int'(NT); t++) begin
        owner_q[t] <= '0;
        ptr_q[t]   <= '0;
        tcnt_q[t]  <= '0;
      end
    end else begin
      lock_q <= lock_d;
      for (int t = 0; t < int'(NT); t++) begin
        owner_q[t] <= owner_d[t];
        ptr_q[t]   <= ptr_d[t];
        tcnt_q[t]  <= tcnt_d[t];
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(NI); i++) begin
        assume ($onehot0(I_req[bit_of(i, 0) +: NT]));
      end
      assert ((I_vreq & ~avail) == '0);
      for (int t = 0; t < int'(NT); t++) begin
        for (int i = 0; i < int'(NI); i++) begin
          assert (!(lock_q[t] && I_vreq[bit_of(i, t)] && (OW'(i) != owner_q[t])));
          for (int j = i + 1; j < int'(NI); j++) begin
            assert (!(I_vreq[bit_of(i, t)] && I_vreq[bit_of(j, t)]));
          end
        end
      end
    end
  end
`endif

endmodule

// File: doc/rsp_xarbiter_lock.md
Name: rsp_xarbiter_lock

Overview:
- Parametrised successor of the response-path crossbar arbiter: NI initiators, NT targets, one round-robin arbiter per target.
- New over the previous generation: packet locking. A target stays granted to one initiator from its first accepted beat until the beat flagged last is accepted, or until an idle timeout expires.
- Sits between the initiator request decode and the crossbar mux select in the generated switch.
- Outputs never grant two initiators to the same target in a cycle.

Parameters:
NI, 5, number of initiators (>=2)
NT, 3, number of targets (>=1)
LOCK_TO, 16, idle cycles allowed while locked before forced release; 0 disables the timeout
TOW, $clog2(LOCK_TO+1), timeout counter width (derived, not overridable)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
I_req  in  NI*NT  request vector; bits [i*NT +: NT] belong to initiator i; each slice is onehot0
I_last  in  NI  initiator i's current beat is the last of its packet
T_rdy  in  NT  target t can accept a beat this cycle
I_vreq  out  NI*NT  grant vector, same layout as I_req; a beat transfers when the bit is 1
T_lock  out  NT  target t is currently locked (registered state)

Behaviour:
- avail[i][t] = I_req[i][t] & T_rdy[t].
- Grant generation is combinational from avail and registered state. vreq implies T_rdy, so a vreq bit equal to 1 means the beat is accepted that cycle.
- Per-target state: lock (IDLE/LOCKED), owner[t] (clog2(NI) bits), ptr[t] round-robin pointer, tcnt[t] (TOW bits).
- IDLE grant: the first i with avail[i][t], searching from ptr[t] upward with wrap at NI-1 -> 0. At most one grant per target.
- LOCKED grant: only owner[t] may be granted, and only when avail[owner][t]. All other initiators are masked even if owner is idle.
- Transition IDLE -> LOCKED: a grant to i with I_last[i]=0. Next cycle owner<=i, tcnt<=0. ptr is unchanged.
- Single-beat packet: IDLE grant with I_last[i]=1. State stays IDLE; next cycle ptr<=(i+1) mod NI.
- Transition LOCKED -> IDLE (packet end): grant to owner with I_last=1. Next cycle ptr<=(owner+1) mod NI and tcnt<=0.
- Idle counting while LOCKED: each cycle without a grant, tcnt increments.
- Timeout: when tcnt==LOCK_TO-1 and no grant, next cycle LOCKED -> IDLE with ptr<=(owner+1) mod NI. The forced release takes effect on the LOCK_TO-th idle cycle. A grant in any cycle clears tcnt to 0.
- With LOCK_TO=0 the lock is held indefinitely until the last beat.
- Back-to-back packets: after a release, the new arbitration in the next cycle uses the updated ptr. There is no bubble beyond the state update.
- Simultaneous grant plus timeout: the grant wins and the lock continues.
- T_rdy low while locked: no grant; counts as an idle cycle.
- Reset: all T_lock=0, ptr=0, owner=0, tcnt=0.
- I_vreq is forced to all zeros while rst=1, regardless of inputs.
- Reset mid-packet drops the lock immediately. First arbitration after reset starts from initiator 0.
- Each initiator holds at most one target grant per cycle, because its I_req slice is onehot0.
- Non-synthesis checks:
  - Assume each I_req slice is onehot0.
  - Assert each target column of I_vreq is onehot0.
  - Assert I_vreq implies I_req & T_rdy.
  - Assert that while T_lock[t] is set, no initiator other than owner[t] is granted t.

Test Plan:
- NI=5,NT=3,LOCK_TO=16. I0..I4 all request T0 with last=1, T_rdy=111, held 5 cycles -> T0 grants rotate I0,I1,I2,I3,I4. T_lock[0] stays 0.
- I1 sends a 3-beat packet to T2 (last on beat 3) while I3 also requests T2 -> I1 granted 3 cycles with T_lock[2]=1 in cycles 2-3. I3 is granted in cycle 4, after the T_lock[2]=0 update.
- I2 locks T1, then drops its request for 16 cycles while I4 requests T1 -> I4 is not granted for cycles 1-15 of the gap. T_lock[1] falls after the 16th idle cycle. I4 is granted the following cycle.
- Locked owner I0 on T0 with T_rdy[0]=0 for 3 cycles, then ready, last beat -> no grant for 3 cycles, then one grant. Lock releases and ptr[0]=1.
- Assert rst during a locked packet on T1 -> I_vreq=0 while rst=1. T_lock=0 after reset. The next T1 request from I3 and I0 together grants I0.
- Concurrent traffic: I0->T0, I1->T1 and I2->T2, all multi-beat -> three independent grants every cycle. No column carries two ones, and all T_lock bits are set.
